// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a blink phase and a two-digit countdown.
// seg_out/dig_out are registered and follow scan_idx one cycle later; countdown outputs are registered.
// No backpressure: inputs are sampled every cycle and the scan runs freely.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int TICK_DIV   = 100000000,
  parameter int CD_INIT    = 30,
  parameter int LZ_BLANK   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seg_en,
  input  logic [7*NUM_DIGITS/2-1:0] val_in,
  input  logic [NUM_DIGITS/2-1:0]   blink_mask,
  input  logic                      cd_start,
  input  logic                      cd_abort,
  output logic [7:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     dig_out,
  output logic [2:0]                scan_idx,
  output logic [6:0]                cd_value,
  output logic                      cd_active,
  output logic                      cd_done
);

  localparam int NF = NUM_DIGITS / 2;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(TICK_DIV / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [HW-1:0] blink_cnt;
  logic          blink_phase;
  logic [TW-1:0] tick_q, tick_d;
  logic [6:0]    cd_value_d;
  logic          cd_done_d;
  logic [6:0]    fval, dval;
  logic          fblink, is_tens;
  logic [7:0]    bcd, seg_nxt;

  // Repeated-subtraction binary-to-BCD for 0..99; upper nibble tens, lower nibble ones.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [6:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 8'h3F;
      4'd1: enc = 8'h06;
      4'd2: enc = 8'h5B;
      4'd3: enc = 8'h4F;
      4'd4: enc = 8'h66;
      4'd5: enc = 8'h6D;
      4'd6: enc = 8'h7D;
      4'd7: enc = 8'h27;
      4'd8: enc = 8'h7F;
      4'd9: enc = 8'h67;
      default: enc = 8'h00;
    endcase
  endfunction

  // Scan prescaler: hold each digit SCAN_DIV cycles, then step scan_idx with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= 3'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // Blink phase: free-running half-period counter, independent of the countdown tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == HW'(TICK_DIV / 2 - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + HW'(1);
    end
  end

  // Countdown FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      cd_value <= 7'd0;
      cd_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      cd_value <= cd_value_d;
      cd_done  <= cd_done_d;
    end
  end

  // Countdown next state: abort beats start; start (re)loads; RUN decrements on tick wrap.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    cd_value_d = cd_value;
    cd_done_d  = 1'b0;
    if (cd_abort) begin
      state_d    = IDLE;
      tick_d     = '0;
      cd_value_d = 7'd0;
    end else if (cd_start) begin
      tick_d = '0;
      if (CD_INIT == 0) begin
        state_d    = IDLE;
        cd_value_d = 7'd0;
        cd_done_d  = 1'b1;
      end else begin
        state_d    = RUN;
        cd_value_d = 7'(CD_INIT);
      end
    end else if (state_q == RUN) begin
      if (tick_q == TW'(TICK_DIV - 1)) begin
        tick_d     = '0;
        cd_value_d = cd_value - 7'd1;
        if (cd_value == 7'd1) begin
          cd_done_d = 1'b1;
          state_d   = IDLE;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  assign cd_active = (state_q == RUN);

  // Pick the segment pattern for the digit currently addressed by scan_idx.
  always_comb begin
    fval   = 7'd0;
    fblink = 1'b0;
    for (int k = 0; k < NF; k++) begin
      if (scan_idx[2:1] == 2'(k)) begin
        fval   = val_in[7*k +: 7];
        fblink = blink_mask[k];
      end
    end
    is_tens = ~scan_idx[0];
    dval    = cd_active ? cd_value : fval;
    bcd     = to_bcd(dval);
    seg_nxt = 8'h00;
    if (cd_active) begin
      if (scan_idx[2:1] == 2'd0)
        seg_nxt = enc(is_tens ? bcd[7:4] : bcd[3:0]);
    end else if (blink_phase && fblink) begin
      seg_nxt = 8'h00;
    end else if (fval > 7'd99) begin
      seg_nxt = 8'h40;
    end else if (is_tens && (LZ_BLANK != 0) && (fval < 7'd10)) begin
      seg_nxt = 8'h00;
    end else begin
      seg_nxt = enc(is_tens ? bcd[7:4] : bcd[3:0]);
    end
  end

  // Output registers: one cycle behind scan_idx; seg_en only gates the digit enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= 8'h00;
      dig_out <= '0;
    end else begin
      seg_out <= seg_nxt;
      dig_out <= seg_en ? (NUM_DIGITS'(1) << scan_idx) : '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: reference model plus display scoreboard.
// Expected seg/dig are queued when an edge is driven and compared one cycle later.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 2;
  localparam int TD = 8;
  localparam int CI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_en;
  logic [13:0] val_in;
  logic [1:0]  blink_mask;
  logic        cd_start;
  logic        cd_abort;
  logic [7:0]  seg_out;
  logic [3:0]  dig_out;
  logic [2:0]  scan_idx;
  logic [6:0]  cd_value;
  logic        cd_active;
  logic        cd_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       seg_chk;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] seg_tbl [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h27, 8'h7F, 8'h67};

  // reference model state (value after the most recent rising edge)
  int m_presc, m_scan, m_bcnt, m_tick, m_cd;
  bit m_phase, m_run, m_done, m_valid;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .TICK_DIV(TD), .CD_INIT(CI), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .seg_en(seg_en), .val_in(val_in),
    .blink_mask(blink_mask), .cd_start(cd_start), .cd_abort(cd_abort),
    .seg_out(seg_out), .dig_out(dig_out), .scan_idx(scan_idx),
    .cd_value(cd_value), .cd_active(cd_active), .cd_done(cd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg();
    int  fld;
    int  v;
    bit  tens;
    fld  = m_scan / 2;
    tens = (m_scan % 2) == 0;
    if (m_run) begin
      if (fld != 0) return 8'h00;
      v = m_cd;
      return seg_tbl[tens ? v / 10 : v % 10];
    end
    v = (fld == 0) ? int'(val_in[6:0]) : int'(val_in[13:7]);
    if (m_phase && blink_mask[fld]) return 8'h00;
    if (v > 99) return 8'h40;
    if (tens && v < 10) return 8'h00;
    return seg_tbl[tens ? v / 10 : v % 10];
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (m_valid) begin
      chk("scan_idx", 32'(scan_idx), 32'(m_scan));
      chk("cd_value", 32'(cd_value), 32'(m_cd));
      chk("cd_active", 32'(cd_active), 32'(m_run));
      chk("cd_done", 32'(cd_done), 32'(m_done));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dig_out", 32'(dig_out), 32'(e.dig));
        if (e.seg_chk) chk("seg_out", 32'(seg_out), 32'(e.seg));
      end
    end
    // expectation for the upcoming edge, from the state before it
    if (rst) begin
      e.seg = 8'h00; e.dig = 4'h0; e.seg_chk = 1'b1;
    end else begin
      e.dig     = seg_en ? 4'(1 << m_scan) : 4'h0;
      e.seg     = model_seg();
      e.seg_chk = seg_en;
    end
    if (rst || m_valid) exp_q.push_back(e);
    // advance the model across the edge
    if (rst) begin
      m_presc = 0; m_scan = 0; m_bcnt = 0; m_phase = 0;
      m_tick = 0; m_cd = 0; m_run = 0; m_done = 0; m_valid = 1;
    end else begin
      if (m_presc == SD - 1) begin m_presc = 0; m_scan = (m_scan + 1) % ND; end
      else m_presc++;
      if (m_bcnt == TD / 2 - 1) begin m_bcnt = 0; m_phase = !m_phase; end
      else m_bcnt++;
      m_done = 0;
      if (cd_abort) begin
        m_run = 0; m_cd = 0;
      end else if (cd_start) begin
        m_run = 1; m_cd = CI; m_tick = 0;
      end else if (m_run) begin
        if (m_tick == TD - 1) begin
          m_tick = 0; m_cd--;
          if (m_cd == 0) begin m_done = 1; m_run = 0; end
        end else m_tick++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    cd_start = 1'b1; tick(); cd_start = 1'b0;
  endtask

  initial begin
    m_valid = 0;
    rst = 1'b1; seg_en = 1'b1; val_in = {7'd42, 7'd5}; blink_mask = 2'b00;
    cd_start = 1'b0; cd_abort = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk("reset_seg_out", 32'(seg_out), 32'h0);
    chk("reset_dig_out", 32'(dig_out), 32'h0);

    // plain scan with leading-zero blanking on field 0
    ticks(16);
    // out-of-range field, then digits disabled
    val_in = {7'd120, 7'd5};
    ticks(8);
    seg_en = 1'b0;
    ticks(8);
    seg_en = 1'b1;
    // blink field 0, then field 1
    val_in = {7'd42, 7'd5};
    blink_mask = 2'b01;
    ticks(24);
    blink_mask = 2'b10;
    val_in = {7'd0, 7'd99};
    ticks(16);

    // countdown with val_in/blink_mask that must be ignored
    val_in = {7'd77, 7'd88}; blink_mask = 2'b11;
    pulse_start();
    chk("cd_load", 32'(cd_value), 32'd3);
    ticks(34);
    chk("cd_end_idle", 32'(cd_active), 32'd0);

    // start and abort together: abort wins
    cd_start = 1'b1; cd_abort = 1'b1; tick(); cd_start = 1'b0; cd_abort = 1'b0;
    chk("race_cd_value", 32'(cd_value), 32'd0);
    ticks(4);
    // restart at cd_value==1
    pulse_start();
    for (int i = 0; i < 40 && cd_value != 7'd1; i++) tick();
    chk("cd_reach1", 32'(cd_value), 32'd1);
    pulse_start();
    chk("cd_reload", 32'(cd_value), 32'd3);
    ticks(30);

    // reset in the middle of a countdown
    pulse_start();
    for (int i = 0; i < 40 && cd_value != 7'd2; i++) tick();
    chk("cd_reach2", 32'(cd_value), 32'd2);
    rst = 1'b1; cd_start = 1'b1; tick(); rst = 1'b0; cd_start = 1'b0;
    chk("rst_mid_cd", 32'(cd_value), 32'd0);
    ticks(4);
    pulse_start();
    ticks(30);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      val_in     = 14'($urandom);
      if ($urandom_range(0, 3) == 0) val_in[6:0] = 7'($urandom_range(0, 9));
      blink_mask = 2'($urandom);
      seg_en     = ($urandom_range(0, 7) != 0);
      cd_start   = ($urandom_range(0, 29) == 0);
      cd_abort   = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; cd_start = 1'b0; cd_abort = 1'b0;
    ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
